// File: rtl/axi_rd_slave.sv
`timescale 1ns/1ps
// axi_rd_slave
// Single-transaction AXI read slave bridging to a simple synchronous memory
// port. One burst is serviced at a time: each beat is fetched (or flagged as
// an error) and then held on the R channel until the master accepts it.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   ARID..ARPORT       read-address fields (ARPORT accepted, not used)
//   ARVALID/ARREADY    address handshake, ARREADY only while idle
//   RID..RLAST         read-data fields, stable while RVALID && !RREADY
//   RVALID/RREADY      read-data handshake
//   mem_ren            one-cycle read strobe to memory
//   mem_raddr          8-byte-aligned read address
//   mem_rdata          read data, valid the cycle after mem_ren
module axi_rd_slave #(
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter logic [63:0] ADDR_SIZE = 64'h0800_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  ARID,
    input  logic [63:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic [2:0]  ARSIZE,
    input  logic [1:0]  ARBURST,
    input  logic [2:0]  ARPORT,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [3:0]  RID,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        mem_ren,
    output logic [63:0] mem_raddr,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    state_t      state_q, state_d;
    logic        ready_q;      // low until the first edge after reset release
    logic [3:0]  id_q;
    logic [63:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [7:0]  cnt_q;        // beats remaining after the current one
    logic        slverr_q;     // whole burst rejected at acceptance
    logic [1:0]  rresp_q;
    logic        rlast_q;
    logic        first_q;      // first RESP cycle of a fetched beat
    logic [63:0] rdata_q;

    logic        ar_hs, r_hs;
    logic        ar_slverr;
    logic        in_window;
    logic        beat_fetch;
    logic [63:0] step;
    logic [63:0] wrap_mask;
    logic [63:0] next_addr;
    logic [64:0] addr_ext, win_lo, win_hi;

    logic unused_arport;
    assign unused_arport = ^ARPORT;

    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    assign ar_slverr = (ARSIZE > 3'd3) || (ARBURST == 2'b11) ||
                       ((ARBURST == BURST_WRAP) &&
                        !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

    // 65-bit compare so a window ending at the top of the address space works.
    assign addr_ext   = {1'b0, addr_q};
    assign win_lo     = {1'b0, ADDR_BASE};
    assign win_hi     = win_lo + {1'b0, ADDR_SIZE};
    assign in_window  = (addr_ext >= win_lo) && (addr_ext < win_hi);
    assign beat_fetch = !slverr_q && in_window;

    // WRAP keeps the bits above the container size and wraps the rest.
    assign step      = 64'd1 << size_q;
    assign wrap_mask = (({56'd0, len_q} + 64'd1) << size_q) - 64'd1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_addr = addr_q + step;
        if (burst_q == BURST_FIXED)
            next_addr = addr_q;
        else if (burst_q == BURST_WRAP)
            next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = FETCH;
            FETCH:   state_d = RESP;
            RESP:    if (r_hs) state_d = rlast_q ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ARREADY   = (state_q == IDLE) && ready_q;
        RVALID    = (state_q == RESP);
        mem_ren   = (state_q == FETCH) && beat_fetch;
        mem_raddr = {addr_q[63:3], 3'b000};
        RID       = id_q;
        RRESP     = rresp_q;
        RLAST     = rlast_q;
        // Memory data is only guaranteed for one cycle, so it is forwarded
        // on the first RESP cycle and served from rdata_q afterwards.
        if (rresp_q != RESP_OKAY)
            RDATA = 64'h0;
        else if (first_q)
            RDATA = mem_rdata;
        else
            RDATA = rdata_q;
    end

    // Burst datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            slverr_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            first_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        id_q     <= ARID;
                        addr_q   <= ARADDR;
                        len_q    <= ARLEN;
                        size_q   <= ARSIZE;
                        burst_q  <= ARBURST;
                        cnt_q    <= ARLEN;
                        slverr_q <= ar_slverr;
                    end
                end
                FETCH: begin
                    if (slverr_q)
                        rresp_q <= RESP_SLVERR;
                    else if (!in_window)
                        rresp_q <= RESP_DECERR;
                    else
                        rresp_q <= RESP_OKAY;
                    rlast_q <= (cnt_q == 8'd0);
                    first_q <= beat_fetch;
                end
                RESP: begin
                    first_q <= 1'b0;
                    if (first_q)
                        rdata_q <= mem_rdata;
                    if (r_hs && !rlast_q) begin
                        cnt_q  <= cnt_q - 8'd1;
                        addr_q <= next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi_rd_slave.md
AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h8000_0000, lowest decodable byte address.
REQ-002 SHALL have parameter ADDR_SIZE, default 64'h0800_0000, decodable window size in bytes.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ARID in 4, ARADDR in 64, ARLEN in 8, ARSIZE in 3, ARBURST in 2 and ARPORT in 3; these are the AXI read-address fields, and ARPORT is accepted but ignored.
REQ-006 SHALL have ports ARVALID in 1 and ARREADY out 1, the address handshake.
REQ-007 SHALL have ports RID out 4, RDATA out 64, RRESP out 2, RLAST out 1, RVALID out 1 and RREADY in 1, the read-data channel.
REQ-008 SHALL have ports mem_ren out 1, mem_raddr out 64 and mem_rdata in 64; mem_raddr is 8-byte aligned and mem_rdata is valid exactly one cycle after mem_ren.

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, RESP, one transaction at a time, no outstanding queue.
REQ-010 SHALL drive ARREADY=1 only in IDLE; on ARVALID&ARREADY latch ARID/ARADDR/ARLEN/ARSIZE/ARBURST, load beat counter=ARLEN, go FETCH.
REQ-011 SHALL classify at acceptance: ARSIZE>3, ARBURST=2'b11, or WRAP with ARLEN not in {1,3,7,15} -> SLVERR (2'b10) for every beat of the burst.
REQ-012 SHALL in FETCH, for a non-error beat whose address lies in [ADDR_BASE, ADDR_BASE+ADDR_SIZE), assert mem_ren=1 for exactly one cycle with mem_raddr={addr[63:3],3'b0}, then go RESP.
REQ-013 SHALL in FETCH, for an out-of-window beat, keep mem_ren=0 and set beat RRESP=DECERR (2'b11); per-beat check, SLVERR has priority over DECERR.
REQ-014 SHALL in RESP hold RVALID=1 and keep RDATA (registered mem_rdata; 64'h0 on error beats), RID, RRESP and RLAST stable until RREADY=1.
REQ-015 SHALL assert RLAST on the beat where beat counter=0.
REQ-016 SHALL on RVALID&RREADY with RLAST go IDLE, otherwise decrement counter, advance address, go FETCH.
REQ-017 SHALL advance the address as: FIXED unchanged; INCR addr+(1<<size), 64-bit wrap-around; WRAP addr+(1<<size) with bits below log2((ARLEN+1)<<size) wrapping inside the aligned container.
REQ-018 SHALL return the whole aligned doubleword on narrow transfers; lane selection is the master's job.
REQ-019 SHALL give timing: AR handshake in cycle N -> mem_ren in N+1 -> RVALID in N+2; each later beat has RVALID two cycles after the prior beat's R handshake.
REQ-020 SHALL tolerate RREADY held low indefinitely; no timeout, no data loss.
REQ-021 SHALL treat ARLEN=0 as a single beat with RLAST=1.

Reset
REQ-022 SHALL, while rstn=0 (asynchronously), force state=IDLE, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, mem_ren=0 and mem_raddr=0.
REQ-023 SHALL raise ARREADY=1 on the first rising clk after rstn deasserts.
REQ-024 SHALL, on reset mid-burst, abandon the burst silently; no further R beats after release.

Verification
REQ-025 SHALL cover single INCR: ARADDR=0x8000_0010, ARLEN=0, ARSIZE=3, ARID=5 -> mem_raddr=0x8000_0010 at N+1; RVALID at N+2 with RID=5, RRESP=0, RLAST=1 and RDATA=mem word.
REQ-026 SHALL cover INCR burst: ARADDR=0x8000_0000, ARLEN=3, ARSIZE=3, RREADY=1 -> mem_raddr 0x..00, 0x..08, 0x..10, 0x..18; 4 beats with RLAST only on the 4th.
REQ-027 SHALL cover WRAP: ARADDR=0x8000_0018, ARLEN=3, ARSIZE=3 -> mem_raddr 0x..18, 0x..00, 0x..08, 0x..10.
REQ-028 SHALL cover errors: ARADDR=0x1000, ARLEN=1 -> 2 beats RRESP=2'b11, RDATA=0, mem_ren never 1; ARSIZE=4 -> RRESP=2'b10.
REQ-029 SHALL cover backpressure: RREADY=0 for 10 cycles on beat 0 -> R outputs stable and ARREADY=0 throughout; beat 1 follows 2 cycles after the handshake.
REQ-030 SHALL cover async reset: rstn pulsed low between clock edges in RESP of a 4-beat burst -> RVALID=0 immediately; ARREADY=1 at the first edge after release; no stale beats.
